// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and defaults for the hazard scoreboard and its bus watchdog.
package hazard_scoreboard_pkg;

   localparam int REG_ADDR_W          = 5;
   localparam int DEFAULT_BUS_TIMEOUT = 255;

   typedef enum logic [2:0] {
      NONE,
      LOAD_USE,
      SB_RAW,
      SB_WAW,
      MC_BUSY,
      BUS
   } hazard_cause_t;

   // True for causes originating in ID; a bus wait alone is not an ID hazard.
   function automatic logic is_id_hazard(input hazard_cause_t cause);
      return (cause == LOAD_USE) || (cause == SB_RAW) ||
             (cause == SB_WAW)   || (cause == MC_BUSY);
   endfunction

endpackage

// File: rtl/hazard_scoreboard_bus_watchdog.sv
// Bus-wait counter: gates the bus stall and emits a one-cycle pulse when a
// wishbone access has been outstanding for BUS_TIMEOUT cycles.
module bus_watchdog #(
   parameter int BUS_TIMEOUT = hazard_scoreboard_pkg::DEFAULT_BUS_TIMEOUT
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic bus_req_i,
   input  logic bus_done_i,
   output logic bus_stall_o,
   output logic bus_timeout_o
);

   localparam int CNT_W = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;

   logic [CNT_W-1:0] r_cnt;
   logic             r_expired;
   logic             w_waiting;
   logic             w_hit;

   // After a timeout the request is no longer stalled until bus_req_i drops.
   assign w_waiting = bus_req_i & ~bus_done_i & ~r_expired;

   generate
      if (BUS_TIMEOUT != 0) begin : g_enabled
         assign w_hit = w_waiting & (r_cnt == CNT_W'(BUS_TIMEOUT - 1));
      end else begin : g_disabled
         assign w_hit = 1'b0;
      end
   endgenerate

   assign bus_stall_o   = w_waiting & ~w_hit;
   assign bus_timeout_o = w_hit;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_cnt     <= '0;
         r_expired <= 1'b0;
      end else if (!bus_req_i) begin
         r_cnt     <= '0;
         r_expired <= 1'b0;
      end else if (bus_done_i) begin
         r_cnt     <= '0;
      end else if (w_hit) begin
         r_cnt     <= '0;
         r_expired <= 1'b1;
      end else if (w_waiting) begin
         r_cnt     <= r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline stall/flush generation for the 5-stage core, with a scoreboard
// tracking destinations of in-flight multi-cycle (MUL/DIV) operations.
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int NUM_REGS    = 32,
   parameter int REG_ADDR_W  = hazard_scoreboard_pkg::REG_ADDR_W,
   parameter int BUS_TIMEOUT = DEFAULT_BUS_TIMEOUT,
   parameter int STALL_CNT_W = 32
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   id_valid_i,
   input  logic [REG_ADDR_W-1:0]  id_rs1_addr_i,
   input  logic [REG_ADDR_W-1:0]  id_rs2_addr_i,
   input  logic [REG_ADDR_W-1:0]  id_rd_addr_i,
   input  logic                   id_is_mc_i,
   input  logic                   mc_busy_i,
   input  logic                   mc_done_i,
   input  logic [REG_ADDR_W-1:0]  mc_rd_addr_i,
   input  logic [REG_ADDR_W-1:0]  ex_rd_addr_i,
   input  logic                   ex_is_load_i,
   input  logic                   ex_is_pc_redirect_i,
   input  logic                   ex_trap_valid_i,
   input  logic                   mem_trap_valid_i,
   input  logic                   wb_trap_valid_i,
   input  logic                   bus_req_i,
   input  logic                   bus_done_i,
   output logic                   if_id_flush_o,
   output logic                   id_ex_flush_o,
   output logic                   ex_mem_flush_o,
   output logic                   mem_wb_flush_o,
   output logic                   if_id_stall_o,
   output logic                   id_ex_stall_o,
   output logic                   ex_mem_stall_o,
   output logic                   mem_wb_stall_o,
   output logic                   mc_kill_o,
   output logic                   bus_timeout_o,
   output logic [NUM_REGS-1:0]    sb_pending_o,
   output logic [STALL_CNT_W-1:0] stall_cycles_o
);

   logic [NUM_REGS-1:0]    r_sb;
   logic [STALL_CNT_W-1:0] r_stall_cnt;

   logic                w_bus_stall;
   logic                w_bus_timeout;
   logic [NUM_REGS-1:0] w_clr_mask;
   logic [NUM_REGS-1:0] w_set_mask;
   logic [NUM_REGS-1:0] w_pend_eff;
   logic                w_load_use;
   logic                w_raw;
   logic                w_waw;
   logic                w_struct;
   logic                w_id_hazard;
   logic                w_any_trap;
   logic                w_late_trap;
   logic                w_if_id_stall;
   logic                w_id_ex_flush;
   logic                w_issue;
   hazard_cause_t       w_cause;

   bus_watchdog #(
      .BUS_TIMEOUT (BUS_TIMEOUT)
   ) u_bus_watchdog (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .bus_req_i     (bus_req_i),
      .bus_done_i    (bus_done_i),
      .bus_stall_o   (w_bus_stall),
      .bus_timeout_o (w_bus_timeout)
   );

   // Per-register clear/set masks; x0 can never become pending.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_masks
         if (gi == 0) begin : g_zero
            assign w_clr_mask[gi] = 1'b0;
            assign w_set_mask[gi] = 1'b0;
         end else begin : g_reg
            assign w_clr_mask[gi] = mc_done_i & (mc_rd_addr_i == REG_ADDR_W'(gi));
            assign w_set_mask[gi] = w_issue & (id_rd_addr_i == REG_ADDR_W'(gi));
         end
      end
   endgenerate

   // A result written back this cycle no longer blocks its readers/writers.
   assign w_pend_eff = r_sb & ~w_clr_mask;

   assign w_load_use = ex_is_load_i && (ex_rd_addr_i != '0) &&
                       ((ex_rd_addr_i == id_rs1_addr_i) || (ex_rd_addr_i == id_rs2_addr_i));
   assign w_raw      = ((id_rs1_addr_i != '0) && w_pend_eff[id_rs1_addr_i]) ||
                       ((id_rs2_addr_i != '0) && w_pend_eff[id_rs2_addr_i]);
   assign w_waw      = (id_rd_addr_i != '0) && w_pend_eff[id_rd_addr_i];
   assign w_struct   = id_is_mc_i & mc_busy_i;

   always_comb begin
      w_cause = NONE;
      if (id_valid_i && w_load_use)    w_cause = LOAD_USE;
      else if (id_valid_i && w_raw)    w_cause = SB_RAW;
      else if (id_valid_i && w_waw)    w_cause = SB_WAW;
      else if (id_valid_i && w_struct) w_cause = MC_BUSY;
      else if (w_bus_stall)            w_cause = BUS;
   end

   assign w_id_hazard   = is_id_hazard(w_cause);
   assign w_late_trap   = mem_trap_valid_i | wb_trap_valid_i;
   assign w_any_trap    = ex_trap_valid_i | w_late_trap;
   assign w_if_id_stall = w_id_hazard | w_bus_stall;
   assign w_id_ex_flush = ((ex_is_pc_redirect_i | w_id_hazard) & ~w_bus_stall) | w_late_trap;
   assign w_issue       = id_valid_i & id_is_mc_i & (id_rd_addr_i != '0) &
                          ~w_if_id_stall & ~w_id_ex_flush;

   // While in reset every pipeline register is flushed and nothing stalls.
   assign if_id_flush_o  = ~rst_ni | ex_is_pc_redirect_i | w_any_trap;
   assign id_ex_flush_o  = ~rst_ni | w_id_ex_flush;
   assign ex_mem_flush_o = ~rst_ni | w_late_trap;
   assign mem_wb_flush_o = ~rst_ni | wb_trap_valid_i;
   assign if_id_stall_o  = rst_ni & w_if_id_stall;
   assign id_ex_stall_o  = rst_ni & w_bus_stall;
   assign ex_mem_stall_o = rst_ni & w_bus_stall;
   assign mem_wb_stall_o = rst_ni & w_bus_stall;
   assign mc_kill_o      = rst_ni & w_any_trap;
   assign bus_timeout_o  = rst_ni & w_bus_timeout;
   assign sb_pending_o   = r_sb;
   assign stall_cycles_o = r_stall_cnt;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_sb        <= '0;
         r_stall_cnt <= '0;
      end else begin
         // Set after clear so a same-cycle reissue to the same rd stays pending.
         if (w_any_trap) r_sb <= '0;
         else            r_sb <= (r_sb & ~w_clr_mask) | w_set_mask;
         if (w_if_id_stall && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomised scoreboard bench: a rule-level model predicts each cycle's
// controls, a monitor compares them against two DUTs (timeout 4 and disabled).
module tb_hazard_scoreboard;

   localparam int NR = 32;
   localparam int T  = 4;

   logic       clk = 1'b0;
   logic       rst_n, id_valid, is_mc, mc_busy, mc_done, ex_is_load, redirect;
   logic       ex_trap, mem_trap, wb_trap, bus_req, bus_done;
   logic [4:0] rs1, rs2, rd, mc_rd, ex_rd;

   logic        if_id_fl, id_ex_fl, ex_mem_fl, mem_wb_fl;
   logic        if_id_st, id_ex_st, ex_mem_st, mem_wb_st, kill, tout;
   logic [31:0] sb, sc;
   logic        if_id_fl_z, id_ex_fl_z, ex_mem_fl_z, mem_wb_fl_z;
   logic        if_id_st_z, id_ex_st_z, ex_mem_st_z, mem_wb_st_z, kill_z, tout_z;
   logic [31:0] sb_z, sc_z;

   always #5 clk = ~clk;

   hazard_scoreboard #(.NUM_REGS(NR), .REG_ADDR_W(5), .BUS_TIMEOUT(T), .STALL_CNT_W(32)) dut (
      .clk_i(clk), .rst_ni(rst_n), .id_valid_i(id_valid),
      .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2), .id_rd_addr_i(rd),
      .id_is_mc_i(is_mc), .mc_busy_i(mc_busy), .mc_done_i(mc_done), .mc_rd_addr_i(mc_rd),
      .ex_rd_addr_i(ex_rd), .ex_is_load_i(ex_is_load), .ex_is_pc_redirect_i(redirect),
      .ex_trap_valid_i(ex_trap), .mem_trap_valid_i(mem_trap), .wb_trap_valid_i(wb_trap),
      .bus_req_i(bus_req), .bus_done_i(bus_done),
      .if_id_flush_o(if_id_fl), .id_ex_flush_o(id_ex_fl), .ex_mem_flush_o(ex_mem_fl),
      .mem_wb_flush_o(mem_wb_fl), .if_id_stall_o(if_id_st), .id_ex_stall_o(id_ex_st),
      .ex_mem_stall_o(ex_mem_st), .mem_wb_stall_o(mem_wb_st), .mc_kill_o(kill),
      .bus_timeout_o(tout), .sb_pending_o(sb), .stall_cycles_o(sc));

   hazard_scoreboard #(.NUM_REGS(NR), .REG_ADDR_W(5), .BUS_TIMEOUT(0), .STALL_CNT_W(32)) dut_z (
      .clk_i(clk), .rst_ni(rst_n), .id_valid_i(id_valid),
      .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2), .id_rd_addr_i(rd),
      .id_is_mc_i(is_mc), .mc_busy_i(mc_busy), .mc_done_i(mc_done), .mc_rd_addr_i(mc_rd),
      .ex_rd_addr_i(ex_rd), .ex_is_load_i(ex_is_load), .ex_is_pc_redirect_i(redirect),
      .ex_trap_valid_i(ex_trap), .mem_trap_valid_i(mem_trap), .wb_trap_valid_i(wb_trap),
      .bus_req_i(bus_req), .bus_done_i(bus_done),
      .if_id_flush_o(if_id_fl_z), .id_ex_flush_o(id_ex_fl_z), .ex_mem_flush_o(ex_mem_fl_z),
      .mem_wb_flush_o(mem_wb_fl_z), .if_id_stall_o(if_id_st_z), .id_ex_stall_o(id_ex_st_z),
      .ex_mem_stall_o(ex_mem_st_z), .mem_wb_stall_o(mem_wb_st_z), .mc_kill_o(kill_z),
      .bus_timeout_o(tout_z), .sb_pending_o(sb_z), .stall_cycles_o(sc_z));

   typedef struct {
      logic [3:0]  fl;
      logic [3:0]  st;
      logic        kill;
      logic        to;
      logic        stz;
      logic        chk_state;
      logic [31:0] sb;
      logic [31:0] sc;
   } exp_t;

   exp_t q[$];

   // Reference state: which registers await a multi-cycle result, how long the
   // current bus request has been waiting, and the total ID stall count.
   bit     m_pend[NR];
   int     m_wait;
   bit     m_gave_up;
   longint m_stalls;
   bit     m_known;
   int     n_tests = 0;
   int     n_fail  = 0;
   int     n_tx    = 0;

   function automatic bit busy_reg(input logic [4:0] r);
      return m_pend[r] && !(mc_done && mc_rd == r);
   endfunction

   task automatic model_push();
      exp_t e;
      bit waiting, hit, bstall, lu, raw, waw, hz, trap, ifst, idexfl, issue;
      for (int i = 0; i < NR; i++) e.sb[i] = m_pend[i];
      e.sc        = m_stalls[31:0];
      e.chk_state = m_known;
      if (!rst_n) begin
         e.fl = 4'hF; e.st = 4'h0; e.kill = 0; e.to = 0; e.stz = 0;
         for (int i = 0; i < NR; i++) m_pend[i] = 0;
         m_wait = 0; m_gave_up = 0; m_stalls = 0; m_known = 1;
      end else begin
         waiting = bus_req && !bus_done && !m_gave_up;
         hit     = waiting && (m_wait == T - 1);
         bstall  = waiting && !hit;
         lu   = ex_is_load && ex_rd != 0 && (ex_rd == rs1 || ex_rd == rs2);
         raw  = (rs1 != 0 && busy_reg(rs1)) || (rs2 != 0 && busy_reg(rs2));
         waw  = rd != 0 && busy_reg(rd);
         hz   = id_valid && (lu || raw || waw || (is_mc && mc_busy));
         trap = ex_trap || mem_trap || wb_trap;
         ifst = hz || bstall;
         idexfl = ((redirect || hz) && !bstall) || mem_trap || wb_trap;
         e.fl = {redirect || trap, idexfl, mem_trap || wb_trap, wb_trap};
         e.st = {ifst, bstall, bstall, bstall};
         e.kill = trap;
         e.to   = hit;
         e.stz  = bus_req && !bus_done;
         issue = id_valid && is_mc && rd != 0 && !ifst && !idexfl;
         if (trap) begin
            for (int i = 0; i < NR; i++) m_pend[i] = 0;
         end else begin
            if (mc_done) m_pend[mc_rd] = 0;
            if (issue)   m_pend[rd] = 1;
         end
         m_pend[0] = 0;
         if (!bus_req)    begin m_wait = 0; m_gave_up = 0; end
         else if (bus_done) m_wait = 0;
         else if (hit)    begin m_wait = 0; m_gave_up = 1; end
         else if (bstall) m_wait = m_wait + 1;
         if (ifst && m_stalls < 64'hFFFF_FFFF) m_stalls = m_stalls + 1;
      end
      q.push_back(e);
   endtask

   task automatic cyc();
      model_push();
      @(negedge clk);
   endtask

   task automatic idle();
      id_valid = 0; is_mc = 0; mc_busy = 0; mc_done = 0; ex_is_load = 0; redirect = 0;
      ex_trap = 0; mem_trap = 0; wb_trap = 0; bus_req = 0; bus_done = 0;
      rs1 = 0; rs2 = 0; rd = 0; mc_rd = 0; ex_rd = 0;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL tx %0d %s: got %h expected %h", n_tx, name, act, exp);
      end
   endtask

   // Monitor: the controls are valid every cycle, so each queued entry is
   // compared shortly before the next rising edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (q.size() > 0) begin
            e = q.pop_front();
            n_tx++;
            $display("[TB] tx %0d rst_n=%0b fl=%b st=%b kill=%0b to=%0b sb=%h sc=%0d",
                     n_tx, rst_n, {if_id_fl, id_ex_fl, ex_mem_fl, mem_wb_fl},
                     {if_id_st, id_ex_st, ex_mem_st, mem_wb_st}, kill, tout, sb, sc);
            chk("flush", 32'({if_id_fl, id_ex_fl, ex_mem_fl, mem_wb_fl}), 32'(e.fl));
            chk("stall", 32'({if_id_st, id_ex_st, ex_mem_st, mem_wb_st}), 32'(e.st));
            chk("mc_kill", 32'(kill), 32'(e.kill));
            chk("bus_timeout", 32'(tout), 32'(e.to));
            chk("nowd_bus_stall", 32'({id_ex_st_z, tout_z}), 32'({e.stz, 1'b0}));
            if (e.chk_state) begin
               chk("sb_pending", sb, e.sb);
               chk("stall_cycles", sc, e.sc);
            end
         end
      end
   end

   initial begin
      int cand[$];
      idle();
      rst_n = 0;
      m_known = 0; m_wait = 0; m_gave_up = 0; m_stalls = 0;
      for (int i = 0; i < NR; i++) m_pend[i] = 0;
      @(negedge clk);
      cyc(); cyc();
      rst_n = 1; cyc();
      // load-use, then the x0 case
      ex_is_load = 1; ex_rd = 5; id_valid = 1; rs1 = 5; cyc();
      idle(); ex_is_load = 1; ex_rd = 0; id_valid = 1; rs1 = 0; cyc();
      // DIV to x7, dependent reader stalls until writeback
      idle(); id_valid = 1; is_mc = 1; rd = 7; cyc();
      idle(); id_valid = 1; rs2 = 7; cyc(); cyc(); cyc();
      mc_done = 1; mc_rd = 7; cyc();
      mc_done = 0; cyc();
      // WAW on x3 and same-cycle clear/reissue
      idle(); id_valid = 1; is_mc = 1; rd = 3; cyc();
      cyc();
      mc_done = 1; mc_rd = 3; cyc();
      idle(); cyc();
      mc_done = 1; mc_rd = 3; cyc();
      // trap with x7 in flight
      idle(); id_valid = 1; is_mc = 1; rd = 7; cyc();
      idle(); wb_trap = 1; cyc();
      idle(); cyc();
      // bus watchdog
      bus_req = 1; repeat (6) cyc();
      bus_req = 0; cyc();
      // reset in the middle of a scoreboard stall
      id_valid = 1; is_mc = 1; rd = 9; cyc();
      idle(); id_valid = 1; rs1 = 9; cyc();
      rst_n = 0; cyc();
      rst_n = 1; cyc();
      idle(); cyc();
      // random traffic
      for (int n = 0; n < 800; n++) begin
         rst_n      = ($urandom_range(0, 199) != 0);
         id_valid   = ($urandom_range(0, 3) != 0);
         rs1        = 5'($urandom_range(0, 7));
         rs2        = 5'($urandom_range(0, 7));
         rd         = 5'($urandom_range(0, 7));
         is_mc      = ($urandom_range(0, 3) == 0);
         mc_busy    = ($urandom_range(0, 3) == 0);
         ex_rd      = 5'($urandom_range(0, 7));
         ex_is_load = ($urandom_range(0, 3) == 0);
         redirect   = ($urandom_range(0, 9) == 0);
         ex_trap    = ($urandom_range(0, 49) == 0);
         mem_trap   = ($urandom_range(0, 49) == 0);
         wb_trap    = ($urandom_range(0, 49) == 0);
         cand.delete();
         for (int i = 1; i < NR; i++) if (m_pend[i]) cand.push_back(i);
         if (cand.size() > 0 && $urandom_range(0, 2) == 0) begin
            mc_done = 1;
            mc_rd   = 5'(cand[$urandom_range(0, cand.size() - 1)]);
         end else begin
            mc_done = ($urandom_range(0, 19) == 0);
            mc_rd   = 5'($urandom_range(0, 7));
         end
         if (bus_req && (bus_done || $urandom_range(0, 9) == 0)) bus_req = 0;
         else if (!bus_req) bus_req = ($urandom_range(0, 4) == 0);
         bus_done = bus_req && ($urandom_range(0, 7) == 0);
         cyc();
      end
      idle();
      @(negedge clk);
      #4;
      chk("queue_drain", 32'(q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the core's combinational hazard logic; generates all pipeline stall/flush controls for the 5-stage core.
- Adds a register scoreboard for variable-latency multi-cycle ops (MUL/DIV unit), WAW protection, multi-cycle unit kill on trap, and a bus-wait timeout watchdog.
- Sits beside the pipeline registers; EX operand forwarding stays a separate block.

Parameters:
- NUM_REGS, 32, architectural register count; rd/rs address 0 is hard-wired zero.
- REG_ADDR_W, 5, register address width, equal to $clog2(NUM_REGS).
- BUS_TIMEOUT, 255, bus-wait cycles before the watchdog fires; 0 disables the watchdog.
- STALL_CNT_W, 32, width of the saturating stall-cycle counter.

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  synchronous active-low reset
- id_valid_i  in  1  ID holds a valid instruction
- id_rs1_addr_i, id_rs2_addr_i  in  REG_ADDR_W  ID source registers
- id_rd_addr_i  in  REG_ADDR_W  ID destination register
- id_is_mc_i  in  1  ID instruction is a multi-cycle op
- mc_busy_i  in  1  multi-cycle unit cannot accept an issue
- mc_done_i  in  1  multi-cycle result written back this cycle
- mc_rd_addr_i  in  REG_ADDR_W  destination of the completing multi-cycle op
- ex_rd_addr_i  in  REG_ADDR_W  EX destination register
- ex_is_load_i  in  1  EX holds a load
- ex_is_pc_redirect_i  in  1  branch/jump taken in EX
- ex_trap_valid_i, mem_trap_valid_i, wb_trap_valid_i  in  1  per-stage trap
- bus_req_i, bus_done_i  in  1  wishbone transaction outstanding / acknowledged
- if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mem_wb_flush_o  out  1  per-register flushes
- if_id_stall_o, id_ex_stall_o, ex_mem_stall_o, mem_wb_stall_o  out  1  per-register stalls
- mc_kill_o  out  1  abort the in-flight multi-cycle op
- bus_timeout_o  out  1  one-cycle watchdog pulse
- sb_pending_o  out  NUM_REGS  scoreboard bits; bit 0 is always 0
- stall_cycles_o  out  STALL_CNT_W  saturating count of if_id_stall_o cycles

Behaviour:
- Reset (rst_ni low at a clock edge):
  - clears the scoreboard, bus counter and stall counter.
  - While rst_ni is low, all four flush outputs read 1, all stall outputs read 0, and mc_kill_o and bus_timeout_o read 0.
- bus_stall = bus_req_i & !bus_done_i & !timeout_hit.
  - Counter increments each bus_stall cycle and clears when bus_req_i is low or bus_done_i is high.
  - timeout_hit is true when BUS_TIMEOUT != 0 and the counter equals BUS_TIMEOUT-1.
  - In that cycle bus_timeout_o=1, the stall is released, and the counter clears. A new count starts only after bus_req_i drops.
- Stalls:
  - ex_mem_stall_o, mem_wb_stall_o and id_ex_stall_o all equal bus_stall.
  - id_hazard, evaluated only when id_valid_i=1, is the OR of:
    - load-use: ex_is_load_i, ex_rd_addr_i!=0, and ex_rd_addr_i matches rs1 or rs2.
    - RAW on a scoreboard bit for rs1 or rs2, excluding x0.
    - WAW: the scoreboard bit for rd is set and rd!=0.
    - structural: id_is_mc_i & mc_busy_i.
  - A matching mc_done_i in the same cycle clears the RAW/WAW hazard for that register (bypass).
  - if_id_stall_o = id_hazard | bus_stall.
- Flushes, with trap priority over everything:
  - if_id_flush_o = ex_redirect | any trap.
  - id_ex_flush_o = ((ex_redirect | id_hazard) & !bus_stall) | mem_trap | wb_trap. id_hazard inserts a bubble.
  - ex_mem_flush_o = mem_trap | wb_trap.
  - mem_wb_flush_o = wb_trap.
- Scoreboard:
  - Set: bit rd is set when issue = id_valid_i & id_is_mc_i & rd!=0 & !if_id_stall_o & !id_ex_flush_o.
  - Clear: bit mc_rd_addr_i is cleared on mc_done_i.
  - Same register set and cleared in the same cycle: the bit ends at 1.
  - Trap: mc_kill_o = ex_trap | mem_trap | wb_trap, asserted combinationally. Any trap clears every bit on the next edge and suppresses that cycle's set.
  - Bit 0 is never set.
- stall_cycles_o increments on each cycle where if_id_stall_o=1 and saturates at all-ones.
- Latency: all stall/flush outputs are combinational on inputs plus state. State updates on the next rising edge.

Decomposition:
- Shared package gets:
  - hazard_cause_t enum: NONE, LOAD_USE, SB_RAW, SB_WAW, MC_BUSY, BUS.
  - localparam default BUS_TIMEOUT.
  - REG_ADDR_W.
- One sub-module: bus_watchdog (counter, timeout pulse, stall gating).

Test Plan:
- Load-use: ex load rd=5, ID rs1=5 -> if_id_stall_o=1, id_ex_flush_o=1 for one cycle; with rs1=0 and rd=0 -> no stall.
- MC RAW: issue DIV rd=7, then ID rs2=7 -> stall until mc_done_i rd=7; released in the done cycle; sb_pending_o[7]=0 after that edge.
- WAW and simultaneous set/clear: mc_done rd=3 while issuing a new MC to rd=3 -> sb_pending_o[3]=1 after the edge.
- Trap with an MC in flight: sb_pending_o=0x80 and wb_trap=1 -> mc_kill_o=1, all four flushes=1, sb_pending_o=0 next cycle.
- Bus timeout (BUS_TIMEOUT=4): bus_req_i held high with no done -> stall for 3 cycles, bus_timeout_o pulse on the 4th cycle with stall=0; BUS_TIMEOUT=0 -> stall held indefinitely.
- Reset mid-stall: rst_ni low during an MC stall -> flushes=1, stalls=0; after release sb_pending_o=0 and stall_cycles_o=0.
